// File: rtl/mul_server.sv
// +----------------------------------------------------------------------------
// | mul_server : round-robin front end sharing one fixed-latency multiplier
// |              core among NCLI clients, with per-client result slots.
// | Revision   : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mul_server #(
  parameter int DWIDTH = 64,
  parameter int NCLI   = 4,
  parameter int LAT    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCLI-1:0]          req_valid,
  output logic [NCLI-1:0]          req_ready,
  input  logic [NCLI*DWIDTH-1:0]   req_a,
  input  logic [NCLI*DWIDTH-1:0]   req_b,
  output logic [NCLI-1:0]          resp_valid,
  input  logic [NCLI-1:0]          resp_ready,
  output logic [NCLI*DWIDTH-1:0]   resp_y,
  output logic                     core_in_valid,
  output logic [DWIDTH-1:0]        core_a,
  output logic [DWIDTH-1:0]        core_b,
  input  logic                     core_out_valid,
  input  logic [DWIDTH-1:0]        core_y,
  output logic                     err,
  output logic [31:0]              op_count
);

  localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam int GW = $clog2(LAT + 1);

  logic [NCLI-1:0]        r_busy;
  logic [IW-1:0]          r_rr_ptr;
  logic                   r_core_in_valid;
  logic [IW-1:0]          r_core_id;
  logic [DWIDTH-1:0]      r_core_a;
  logic [DWIDTH-1:0]      r_core_b;
  logic [LAT-1:0]         r_tag_v;
  logic [IW-1:0]          r_tag_id [LAT];
  logic [GW-1:0]          r_guard;
  logic [NCLI-1:0]        r_resp_valid;
  logic [NCLI*DWIDTH-1:0] r_resp_y;
  logic                   r_err;
  logic [31:0]            r_op_count;

  logic [NCLI-1:0]        w_elig;
  logic [NCLI-1:0]        w_grant;
  logic                   w_gnt_any;
  logic [IW-1:0]          w_gnt_id;
  logic [IW:0]            w_sum;
  logic                   w_head_v;
  logic [IW-1:0]          w_head_id;
  logic                   w_deliver;
  logic                   w_err_set;

  assign w_elig = req_valid & ~r_busy;

  // Round-robin search upward from r_rr_ptr; first eligible client wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_sum     = '0;
    w_grant   = '0;
    for (int k = 0; k < NCLI; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NCLI)) w_sum = w_sum - (IW+1)'(NCLI);
      if (!w_gnt_any && w_elig[w_sum[IW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_sum[IW-1:0];
      end
    end
    w_grant[w_gnt_id] = w_gnt_any & rst_n;
  end

  assign w_head_v  = r_tag_v[LAT-1];
  assign w_head_id = r_tag_id[LAT-1];
  assign w_deliver = core_out_valid & w_head_v;
  // Stray core results are tolerated while the guard drains after reset.
  assign w_err_set = (core_out_valid & ~w_head_v & (r_guard == '0)) |
                     (~core_out_valid & w_head_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy          <= '0;
      r_rr_ptr        <= '0;
      r_core_in_valid <= 1'b0;
      r_core_id       <= '0;
      r_core_a        <= '0;
      r_core_b        <= '0;
      r_tag_v         <= '0;
      for (int j = 0; j < LAT; j++) r_tag_id[j] <= '0;
      r_guard         <= GW'(LAT);
      r_resp_valid    <= '0;
      r_resp_y        <= '0;
      r_err           <= 1'b0;
      r_op_count      <= '0;
    end else begin
      r_core_in_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_core_id  <= w_gnt_id;
        r_core_a   <= req_a[w_gnt_id*DWIDTH +: DWIDTH];
        r_core_b   <= req_b[w_gnt_id*DWIDTH +: DWIDTH];
        r_rr_ptr   <= (w_gnt_id == IW'(NCLI-1)) ? '0 : w_gnt_id + 1'b1;
        r_op_count <= r_op_count + 32'd1;
      end

      // Tags enter with the core strobe so the head meets core_out_valid.
      for (int j = LAT-1; j > 0; j--) begin
        r_tag_v[j]  <= r_tag_v[j-1];
        r_tag_id[j] <= r_tag_id[j-1];
      end
      r_tag_v[0]  <= r_core_in_valid;
      r_tag_id[0] <= r_core_id;

      if (r_guard != '0) r_guard <= r_guard - 1'b1;
      if (w_err_set) r_err <= 1'b1;

      for (int i = 0; i < NCLI; i++) begin
        if (w_grant[i]) begin
          r_busy[i] <= 1'b1;
        end else if (r_resp_valid[i] && resp_ready[i]) begin
          r_busy[i] <= 1'b0;
        end
        if (w_deliver && (w_head_id == IW'(i))) begin
          r_resp_valid[i]                <= 1'b1;
          r_resp_y[i*DWIDTH +: DWIDTH]   <= core_y;
        end else if (r_resp_valid[i] && resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready     = w_grant;
  assign resp_valid    = r_resp_valid;
  assign resp_y        = r_resp_y;
  assign core_in_valid = r_core_in_valid;
  assign core_a        = r_core_a;
  assign core_b        = r_core_b;
  assign err           = r_err;
  assign op_count      = r_op_count;

endmodule

`default_nettype wire
